mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: ADDR_WIDTH, default 32, byte address width; DATA_WIDTH, default 32, word width; the block SHALL support only these defaults.
REQ-002 clock  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 f_req  in  1  fetch port request, held until f_done; f_addr  in  32  burst base byte address; f_size  in  2  access size code.
REQ-005 f_rdata  out  32  fetch read word; f_valid  out  1  f_rdata valid pulse; f_done  out  1  burst complete pulse.
REQ-006 d_req  in  1  data port request, held until d_done; d_rw  in  1  1=write, 0=read; d_addr  in  32; d_size  in  2; d_wdata  in  32  current write word.
REQ-007 d_rdata  out  32; d_valid  out  1; d_wnext  out  1  write word consumed pulse, next word due next cycle; d_done  out  1.
REQ-008 mem_address  out  32; mem_data_in  out  32; mem_access_size  out  2; mem_rw  out  1; mem_enable  out  1; mem_busy  in  1; mem_data_out  in  32.

Function
REQ-009 Size code to beat count: 00=1, 01=4, 10=8, 11=16 words; one beat = one 4-byte word.
REQ-010 States IDLE, RUN, LAST; IDLE->RUN on any req, RUN->LAST on final beat acceptance, LAST->IDLE after one cycle.
REQ-011 In IDLE, requests SHALL be sampled; single requester wins; both requesting -> round-robin, winner is the port not granted last; port, addr, size, rw latched at grant.
REQ-012 Latched base address SHALL have bits [1:0] forced to 0.
REQ-013 In RUN: mem_enable=1, mem_address=base+4*beat (modulo 2^32, wrap permitted), mem_access_size=latched size, mem_rw=latched rw (fetch always 0).
REQ-014 A beat is accepted on a cycle with mem_enable=1 and mem_busy=0; beat counter increments only on acceptance; mem_busy=1 stalls with all mem_* outputs held.
REQ-015 Read: mem_data_out captured the cycle after acceptance and presented on granted port rdata with valid=1 for exactly one cycle.
REQ-016 Write: mem_data_in=d_wdata combinationally; d_wnext=1 on each acceptance cycle.
REQ-017 done SHALL pulse one cycle in LAST, coincident with final read valid; for writes, one cycle after final acceptance.
REQ-018 Latency, mem_busy=0: req high at edge k -> mem_enable from cycle k+1; N-beat read valids at k+2..k+N+1, done at k+N+1; next grant enable no earlier than k+N+3.
REQ-019 req deassertion mid-burst SHALL be ignored; burst completes. Requests arriving outside IDLE wait.
REQ-020 Ungranted port valid, wnext, done SHALL stay 0; rdata of ungranted port SHALL hold last value.

Reset
REQ-021 On reset: state=IDLE, all valid/done/wnext/mem_enable/mem_rw=0, mem_address=0, rdata=0, last-grant=data port (fetch wins first tie).
REQ-022 Reset mid-burst SHALL abandon the burst with no done pulse; operation resumes from IDLE next cycle.

Structure
REQ-023 Package mem_ctrl_pkg SHALL hold size codes, state encoding, beat-count constants and port-select encoding.
REQ-024 Round-robin selection SHALL be sub-module mem_rr_arbiter (2 requests, grant, last-grant register); remainder flat.

Verification
REQ-025 Fetch size 00 read, addr 0x100, mem word 0xDEADBEEF, busy=0 -> enable 1 cycle at 0x100, f_valid+f_done at k+2, f_rdata=0xDEADBEEF.
REQ-026 Data write size 01, addr 0x200, words 1..4 -> addresses 0x200,0x204,0x208,0x20C, four d_wnext pulses, d_done once, mem_rw=1.
REQ-027 Both req at once after reset, both size 00 -> fetch first, data second; repeat tie -> order alternates.
REQ-028 Fetch size 10 with mem_busy=1 on beats 2 and 5 for 3 cycles each -> 8 valids, addresses held during stall, done after 8th.
REQ-029 Data read size 11 at 0xFFFFFFF0 -> addresses wrap 0xFFFFFFF0..0x0000002C; addr 0x103 -> base 0x100.
REQ-030 Reset asserted on beat 3 of size 11 read -> no done, outputs zero next cycle, fresh request served normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared encodings for the two-port memory arbiter
package mem_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // access size codes (words per burst)
  localparam logic [1:0] SIZE_1  = 2'b00;
  localparam logic [1:0] SIZE_4  = 2'b01;
  localparam logic [1:0] SIZE_8  = 2'b10;
  localparam logic [1:0] SIZE_16 = 2'b11;

  // beat counts per size code
  localparam int BEATS_1  = 1;
  localparam int BEATS_4  = 4;
  localparam int BEATS_8  = 8;
  localparam int BEATS_16 = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } state_t;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_t;

  // index of the final beat of a burst for a given size code
  function automatic logic [3:0] last_beat(input logic [1:0] size);
    case (size)
      SIZE_1:  last_beat = 4'(BEATS_1 - 1);
      SIZE_4:  last_beat = 4'(BEATS_4 - 1);
      SIZE_8:  last_beat = 4'(BEATS_8 - 1);
      default: last_beat = 4'(BEATS_16 - 1);
    endcase
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - two-way round-robin selector with last-grant memory
module mem_rr_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  req_fetch,
  input  logic  req_data,
  input  logic  take,
  output port_t grant,
  output logic  any_req
);

  port_t last_grant;

  // on a tie the port that did not win last time is chosen
  always_comb begin
    any_req = req_fetch | req_data;
    if (req_fetch && req_data)
      grant = (last_grant == PORT_DATA) ? PORT_FETCH : PORT_DATA;
    else if (req_fetch)
      grant = PORT_FETCH;
    else
      grant = PORT_DATA;
  end

  // remember the winner whenever a grant is actually taken; data preset so fetch wins first tie
  always_ff @(posedge clock) begin
    if (reset)
      last_grant <= PORT_DATA;
    else if (take && any_req)
      last_grant <= grant;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data port burst arbiter in front of a single memory
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  input  logic [1:0]            f_size,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  f_valid,
  output logic                  f_done,
  input  logic                  d_req,
  input  logic                  d_rw,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [1:0]            d_size,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_valid,
  output logic                  d_wnext,
  output logic                  d_done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [1:0]            mem_access_size,
  output logic                  mem_rw,
  output logic                  mem_enable,
  input  logic                  mem_busy,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  state_t                state, state_next;
  port_t                 grant, port_q;
  logic                  any_req;
  logic                  rw_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [3:0]            beat_q;
  logic                  accept;
  logic                  final_beat;
  logic                  take;

  assign take       = (state == ST_IDLE);
  assign accept     = (state == ST_RUN) && !mem_busy;
  assign final_beat = (beat_q == last_beat(size_q));

  mem_rr_arbiter u_rr (
    .clock     (clock),
    .reset     (reset),
    .req_fetch (f_req),
    .req_data  (d_req),
    .take      (take),
    .grant     (grant),
    .any_req   (any_req)
  );

  // state register
  always_ff @(posedge clock) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // next state: start on any request, finish after the final accepted beat
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (any_req) state_next = ST_RUN;
      ST_RUN:  if (accept && final_beat) state_next = ST_LAST;
      ST_LAST: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // memory-side and handshake outputs decoded from state and the latched burst
  always_comb begin
    mem_enable      = (state == ST_RUN);
    mem_address     = mem_enable ? base_q + {{(ADDR_WIDTH-6){1'b0}}, beat_q, 2'b00} : '0;
    mem_access_size = size_q;
    mem_rw          = mem_enable & rw_q;
    mem_data_in     = d_wdata;
    d_wnext         = accept && rw_q && (port_q == PORT_DATA);
    f_done          = (state == ST_LAST) && (port_q == PORT_FETCH);
    d_done          = (state == ST_LAST) && (port_q == PORT_DATA);
  end

  // latch the winning request at grant and advance the beat on every acceptance
  always_ff @(posedge clock) begin
    if (reset) begin
      port_q <= PORT_FETCH;
      rw_q   <= 1'b0;
      size_q <= SIZE_1;
      base_q <= '0;
      beat_q <= '0;
    end else if (take && any_req) begin
      port_q <= grant;
      rw_q   <= (grant == PORT_DATA) ? d_rw : 1'b0;
      size_q <= (grant == PORT_DATA) ? d_size : f_size;
      base_q <= (grant == PORT_DATA) ? {d_addr[ADDR_WIDTH-1:2], 2'b00}
                                     : {f_addr[ADDR_WIDTH-1:2], 2'b00};
      beat_q <= '0;
    end else if (accept) begin
      beat_q <= beat_q + 4'd1;
    end
  end

  // read return: one-cycle valid per accepted read beat, rdata holds between beats
  always_ff @(posedge clock) begin
    if (reset) begin
      f_valid <= 1'b0;
      d_valid <= 1'b0;
      f_rdata <= '0;
      d_rdata <= '0;
    end else begin
      f_valid <= accept && !rw_q && (port_q == PORT_FETCH);
      d_valid <= accept && !rw_q && (port_q == PORT_DATA);
      if (accept && !rw_q && (port_q == PORT_FETCH))
        f_rdata <= mem_data_out;
      if (accept && !rw_q && (port_q == PORT_DATA))
        d_rdata <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0;
  logic [1:0]  f_size = '0;
  logic [31:0] f_rdata;
  logic        f_valid, f_done;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b0;
  logic [31:0] d_addr = '0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_valid, d_wnext, d_done;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic [1:0]  mem_access_size;
  logic        mem_rw, mem_enable;
  logic        mem_busy = 1'b0;

  always #5 clock = ~clock;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] wval(input logic [31:0] seed, input int beat);
    return seed + 32'(beat) + 32'd1;
  endfunction

  function automatic int beats_of(input logic [1:0] s);
    case (s)
      2'b00: return 1;
      2'b01: return 4;
      2'b10: return 8;
      default: return 16;
    endcase
  endfunction

  assign mem_data_out = word_of(mem_address);

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_size(f_size),
    .f_rdata(f_rdata), .f_valid(f_valid), .f_done(f_done),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_wnext(d_wnext), .d_done(d_done),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_access_size(mem_access_size),
    .mem_rw(mem_rw), .mem_enable(mem_enable), .mem_busy(mem_busy), .mem_data_out(mem_data_out)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] seed;
  } txn_t;

  txn_t fq[$];
  txn_t dq[$];
  txn_t f_cur, d_cur;
  bit   f_act = 0, d_act = 0, f_drop = 0, d_drop = 0, f_granted = 0, d_granted = 0;

  // reference model: burst in progress, described by phase/port/beat
  int          m_phase = 0;   // 0 idle, 1 transferring, 2 completion cycle
  bit          m_port = 0;    // 0 fetch, 1 data
  bit          m_last = 1;    // port granted most recently
  bit          m_rw = 0;
  logic [31:0] m_base = '0;
  logic [1:0]  m_size = '0;
  logic [31:0] m_seed = '0;
  int          m_n = 0, m_beat = 0;
  bit          pend_f = 0, pend_d = 0, post_reset = 0;
  logic [31:0] exp_f = '0, exp_d = '0;

  int  busy_mode = 0;
  int  stall_cnt = 0;
  bit  reset_arm = 0;
  int  n_fvalid = 0, n_dvalid = 0, n_wnext = 0, n_fdone = 0, n_ddone = 0;
  bit  done_log[$];

  task automatic step();
    bit acc, do_rst;
    @(negedge clock);
    reset = 1'b0;
    if (!f_act && fq.size() > 0) begin f_cur = fq.pop_front(); f_act = 1; f_drop = 0; f_granted = 0; end
    if (!d_act && dq.size() > 0) begin d_cur = dq.pop_front(); d_act = 1; d_drop = 0; d_granted = 0; end
    f_req  = f_act && !f_drop;
    f_addr = f_granted ? $urandom : f_cur.addr;
    f_size = f_granted ? 2'($urandom) : f_cur.size;
    d_req  = d_act && !d_drop;
    d_addr = d_granted ? $urandom : d_cur.addr;
    d_size = d_granted ? 2'($urandom) : d_cur.size;
    d_rw   = d_granted ? 1'($urandom) : d_cur.rw;
    d_wdata = (m_phase == 1 && m_port && m_rw) ? wval(m_seed, m_beat) : $urandom;
    case (busy_mode)
      1: mem_busy = ($urandom_range(3) == 0);
      2: mem_busy = (m_phase == 1) && (m_beat == 2 || m_beat == 5) && (stall_cnt < 3);
      default: mem_busy = 1'b0;
    endcase
    if (mem_busy) stall_cnt++;
    do_rst = reset_arm && m_phase == 1 && m_beat == 3;
    if (do_rst) begin reset = 1'b1; reset_arm = 0; end
    #1;
    acc = (m_phase == 1) && !mem_busy;
    check("mem_enable", mem_enable, m_phase == 1);
    if (m_phase == 1) begin
      check("mem_address", mem_address, m_base + 32'(4 * m_beat));
      check("mem_rw", mem_rw, m_rw);
      check("mem_access_size", mem_access_size, m_size);
    end else begin
      check("mem_rw_idle", mem_rw, 0);
    end
    if (post_reset) begin
      check("mem_address_after_reset", mem_address, 0);
      post_reset = 0;
    end
    check("d_wnext", d_wnext, acc && m_port && m_rw);
    if (acc && m_rw) check("mem_data_in", mem_data_in, wval(m_seed, m_beat));
    check("f_valid", f_valid, pend_f);
    check("d_valid", d_valid, pend_d);
    check("f_rdata", f_rdata, exp_f);
    check("d_rdata", d_rdata, exp_d);
    check("f_done", f_done, m_phase == 2 && !m_port);
    check("d_done", d_done, m_phase == 2 && m_port);
    if (f_valid) n_fvalid++;
    if (d_valid) n_dvalid++;
    if (d_wnext) n_wnext++;
    if (f_done) begin n_fdone++; done_log.push_back(0); end
    if (d_done) begin n_ddone++; done_log.push_back(1); end
    // advance the model to what the next edge should produce
    if (do_rst) begin
      m_phase = 0; m_last = 1; pend_f = 0; pend_d = 0; exp_f = '0; exp_d = '0; post_reset = 1;
      if (m_port) d_act = 0; else f_act = 0;
      stall_cnt = 0;
    end else begin
      pend_f = acc && !m_rw && !m_port;
      pend_d = acc && !m_rw && m_port;
      if (pend_f) exp_f = word_of(m_base + 32'(4 * m_beat));
      if (pend_d) exp_d = word_of(m_base + 32'(4 * m_beat));
      if (m_phase == 1) begin
        if (acc) begin
          m_beat++;
          stall_cnt = 0;
          if (m_beat == m_n) m_phase = 2;
        end
        if ($urandom_range(3) == 0) begin
          if (m_port) d_drop = 1; else f_drop = 1;
        end
      end else if (m_phase == 2) begin
        m_phase = 0;
        if (m_port) d_act = 0; else f_act = 0;
      end else if (f_req || d_req) begin
        m_port = (f_req && d_req) ? !m_last : d_req;
        m_last = m_port;
        if (m_port) begin
          m_rw = d_cur.rw; m_base = d_cur.addr & ~32'd3; m_size = d_cur.size; m_seed = d_cur.seed;
          d_granted = 1;
        end else begin
          m_rw = 0; m_base = f_cur.addr & ~32'd3; m_size = f_cur.size; m_seed = f_cur.seed;
          f_granted = 1;
        end
        m_n = beats_of(m_size);
        m_beat = 0;
        stall_cnt = 0;
        m_phase = 1;
      end
    end
  endtask

  task automatic run(input int max_cycles);
    int cnt;
    cnt = 0;
    while ((fq.size() > 0 || dq.size() > 0 || f_act || d_act || m_phase != 0) && cnt < max_cycles) begin
      step();
      cnt++;
    end
    check("run_within_budget", cnt < max_cycles, 1);
    step();
  endtask

  function automatic txn_t mk(input bit rw, input logic [31:0] addr, input logic [1:0] size,
                              input logic [31:0] seed);
    txn_t t;
    t.rw = rw; t.addr = addr; t.size = size; t.seed = seed;
    return t;
  endfunction

  initial begin
    int base_d;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    check("reset_mem_enable", mem_enable, 0);
    check("reset_mem_rw", mem_rw, 0);
    check("reset_mem_address", mem_address, 0);
    check("reset_f_valid", f_valid, 0);
    check("reset_d_valid", d_valid, 0);
    check("reset_f_rdata", f_rdata, 0);
    check("reset_d_rdata", d_rdata, 0);
    check("reset_dones", {f_done, d_done, d_wnext}, 0);

    // single-word fetch at 0x100
    fq.push_back(mk(0, 32'h100, 2'b00, 0));
    run(50);
    check("fetch_single_rdata", f_rdata, 32'hDEAD_BEEF);
    check("fetch_single_valid_count", n_fvalid, 1);

    // four-word data write at 0x200, words 1..4
    dq.push_back(mk(1, 32'h200, 2'b01, 0));
    run(50);
    check("write4_wnext_count", n_wnext, 4);
    check("write4_done_count", n_ddone, 1);

    // simultaneous requests: fetch first, then data, twice
    done_log.delete();
    fq.push_back(mk(0, 32'h40, 2'b00, 0));
    dq.push_back(mk(0, 32'h80, 2'b00, 0));
    fq.push_back(mk(0, 32'h44, 2'b00, 0));
    dq.push_back(mk(1, 32'h84, 2'b00, 32'h77));
    run(80);
    check("tie_done_count", done_log.size(), 4);
    if (done_log.size() == 4) begin
      check("tie1_first", done_log[0], 0);
      check("tie1_second", done_log[1], 1);
      check("tie2_first", done_log[2], 0);
      check("tie2_second", done_log[3], 1);
    end

    // eight-word fetch with stalls on beats 2 and 5
    n_fvalid = 0;
    busy_mode = 2;
    fq.push_back(mk(0, 32'h1000, 2'b10, 0));
    run(80);
    busy_mode = 0;
    check("stall_fetch_valid_count", n_fvalid, 8);

    // sixteen-word read wrapping through zero, then an unaligned base
    n_dvalid = 0;
    dq.push_back(mk(0, 32'hFFFF_FFF0, 2'b11, 0));
    dq.push_back(mk(0, 32'h103, 2'b00, 0));
    run(100);
    check("wrap_read_valid_count", n_dvalid, 17);
    check("unaligned_rdata", d_rdata, 32'hDEAD_BEEF);

    // reset on beat 3 of a sixteen-word read abandons it; a fresh request then completes
    base_d = n_ddone;
    reset_arm = 1;
    dq.push_back(mk(0, 32'h400, 2'b11, 0));
    run(60);
    check("reset_midburst_no_done", n_ddone, base_d);
    fq.push_back(mk(0, 32'h100, 2'b00, 0));
    run(50);
    check("after_reset_fetch_rdata", f_rdata, 32'hDEAD_BEEF);

    // randomized traffic on both ports with random stalls
    busy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      fq.push_back(mk(0, $urandom, 2'($urandom), 0));
      dq.push_back(mk(1'($urandom), $urandom, 2'($urandom), $urandom));
    end
    run(20000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
